// File: rtl/transfer_scheduler.sv
// Serialises DRAM<->GLB transfer requests onto the interface controller; grant/start one cycle after req, done one cycle after controller done.
// Requests are level-held until done; a busy controller (transfer=1) stalls the start pulse in ISSUE with the watchdog running.
module transfer_scheduler #(
   parameter int ADDR_WIDTH = 20,
   parameter int TIMEOUT_W  = 24
) (
   input  logic                  core_clk,
   input  logic                  core_reset_n,
   input  logic                  ifmap_req,
   input  logic                  filter_req,
   input  logic                  bias_req,
   input  logic                  back_req,
   input  logic [ADDR_WIDTH-1:0] ifmap_words,
   input  logic [ADDR_WIDTH-1:0] filter_words,
   input  logic [ADDR_WIDTH-1:0] bias_words,
   input  logic [ADDR_WIDTH-1:0] back_words,
   input  logic                  transfer,
   input  logic                  ifmap_transfer_done,
   input  logic                  filter_transfer_done,
   input  logic                  bias_transfer_done,
   input  logic                  back_transfer_done,
   input  logic                  clear_err,
   output logic                  start_forward,
   output logic                  start_backward,
   output logic [1:0]            ifmap_filter_bias_transfer,
   output logic [ADDR_WIDTH-1:0] words_num,
   output logic [3:0]            grant,
   output logic [3:0]            done,
   output logic                  busy,
   output logic                  err_timeout,
   output logic                  err_protocol
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, COMPLETE} state_t;

   state_t                state, state_nxt;
   logic [3:0]            grant_nxt;
   logic [ADDR_WIDTH-1:0] words_nxt;
   logic [1:0]            type_nxt;
   logic [TIMEOUT_W-1:0]  wdog, wdog_nxt;
   logic [1:0]            rr_ptr, rr_nxt;
   logic                  tout_set, proto_set;

   logic [3:0]            done_in;
   logic [2:0]            fwd_req;
   logic                  fwd_hit;
   logic [1:0]            fwd_idx;
   logic [2:0]            scan_idx;
   logic [ADDR_WIDTH-1:0] fwd_words;

   assign done_in = {back_transfer_done, bias_transfer_done, filter_transfer_done, ifmap_transfer_done};
   assign fwd_req = {bias_req, filter_req, ifmap_req};

   // Round-robin scan: walk offsets high to low so the nearest requester after rr_ptr wins last.
   always_comb begin
      fwd_hit  = 1'b0;
      fwd_idx  = rr_ptr;
      scan_idx = 3'd0;
      for (int i = 2; i >= 0; i--) begin
         scan_idx = {1'b0, rr_ptr} + 3'(i);
         if (scan_idx >= 3'd3) begin
            scan_idx = scan_idx - 3'd3;
         end
         if (fwd_req[scan_idx[1:0]]) begin
            fwd_hit = 1'b1;
            fwd_idx = scan_idx[1:0];
         end
      end
   end

   always_comb begin
      case (fwd_idx)
         2'd1:    fwd_words = filter_words;
         2'd2:    fwd_words = bias_words;
         default: fwd_words = ifmap_words;
      endcase
   end

   always_comb begin
      state_nxt = state;
      grant_nxt = grant;
      words_nxt = words_num;
      type_nxt  = ifmap_filter_bias_transfer;
      wdog_nxt  = wdog;
      rr_nxt    = rr_ptr;
      tout_set  = 1'b0;
      proto_set = 1'b0;
      case (state)
         IDLE: begin
            if (back_req) begin
               grant_nxt = 4'b1000;
               words_nxt = back_words;
               wdog_nxt  = '0;
               state_nxt = (back_words != '0) ? ISSUE : COMPLETE;
            end else if (fwd_hit) begin
               grant_nxt = 4'b0001 << fwd_idx;
               words_nxt = fwd_words;
               type_nxt  = fwd_idx;
               wdog_nxt  = '0;
               state_nxt = (fwd_words != '0) ? ISSUE : COMPLETE;
            end
         end
         ISSUE: begin
            if (wdog != '1) begin
               wdog_nxt = wdog + TIMEOUT_W'(1);
            end
            if (!transfer) begin
               state_nxt = WAIT_DONE;
            end
         end
         WAIT_DONE: begin
            wdog_nxt = wdog + TIMEOUT_W'(1);
            if ((done_in & ~grant) != 4'b0) begin
               proto_set = 1'b1;
            end
            // A matching done beats a watchdog expiry in the same cycle.
            if ((done_in & grant) != 4'b0) begin
               state_nxt = COMPLETE;
            end else if (wdog == '1) begin
               tout_set  = 1'b1;
               grant_nxt = 4'b0;
               state_nxt = IDLE;
            end
         end
         COMPLETE: begin
            grant_nxt = 4'b0;
            state_nxt = IDLE;
            if (grant[0]) rr_nxt = 2'd1;
            if (grant[1]) rr_nxt = 2'd2;
            if (grant[2]) rr_nxt = 2'd0;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge core_clk or negedge core_reset_n) begin
      if (!core_reset_n) begin
         state                      <= IDLE;
         grant                      <= 4'b0;
         words_num                  <= '0;
         ifmap_filter_bias_transfer <= 2'b00;
         wdog                       <= '0;
         rr_ptr                     <= 2'd0;
         err_timeout                <= 1'b0;
         err_protocol               <= 1'b0;
      end else begin
         state                      <= state_nxt;
         grant                      <= grant_nxt;
         words_num                  <= words_nxt;
         ifmap_filter_bias_transfer <= type_nxt;
         wdog                       <= wdog_nxt;
         rr_ptr                     <= rr_nxt;
         err_timeout                <= (err_timeout & ~clear_err) | tout_set;
         err_protocol               <= (err_protocol & ~clear_err) | proto_set;
      end
   end

   // Start is combinational on transfer so it fires in the first ISSUE cycle the controller is idle.
   assign start_forward  = (state == ISSUE) && !transfer && !grant[3];
   assign start_backward = (state == ISSUE) && !transfer && grant[3];
   assign done           = (state == COMPLETE) ? grant : 4'b0;
   assign busy           = (state != IDLE);

endmodule

// File: tb/tb_transfer_scheduler.sv
// Directed bench for transfer_scheduler: default instance for arbitration/latency/errors, TIMEOUT_W=4 instance for watchdog cases.
module tb_transfer_scheduler;

   logic        core_clk = 1'b0;
   logic        core_reset_n;
   logic        ifmap_req, filter_req, bias_req, back_req;
   logic [19:0] ifmap_words, filter_words, bias_words, back_words;
   logic        transfer;
   logic        ifmap_transfer_done, filter_transfer_done, bias_transfer_done, back_transfer_done;
   logic        clear_err;

   logic        start_forward, start_backward, busy, err_timeout, err_protocol;
   logic [1:0]  ifmap_filter_bias_transfer;
   logic [19:0] words_num;
   logic [3:0]  grant, done;

   logic        t_start_forward, t_start_backward, t_busy, t_err_timeout, t_err_protocol;
   logic [1:0]  t_ifmap_filter_bias_transfer;
   logic [19:0] t_words_num;
   logic [3:0]  t_grant, t_done;

   logic [63:0] main_outs, t_outs;
   assign main_outs = {29'd0, start_forward, start_backward, ifmap_filter_bias_transfer, words_num,
                       grant, done, busy, err_timeout, err_protocol};
   assign t_outs    = {29'd0, t_start_forward, t_start_backward, t_ifmap_filter_bias_transfer, t_words_num,
                       t_grant, t_done, t_busy, t_err_timeout, t_err_protocol};

   int total = 0;
   int bad   = 0;
   int cnt;
   logic [3:0] acc;

   always #5 core_clk = ~core_clk;

   transfer_scheduler #(.ADDR_WIDTH(20), .TIMEOUT_W(24)) u_dut (
      .core_clk(core_clk), .core_reset_n(core_reset_n),
      .ifmap_req(ifmap_req), .filter_req(filter_req), .bias_req(bias_req), .back_req(back_req),
      .ifmap_words(ifmap_words), .filter_words(filter_words), .bias_words(bias_words), .back_words(back_words),
      .transfer(transfer),
      .ifmap_transfer_done(ifmap_transfer_done), .filter_transfer_done(filter_transfer_done),
      .bias_transfer_done(bias_transfer_done), .back_transfer_done(back_transfer_done),
      .clear_err(clear_err),
      .start_forward(start_forward), .start_backward(start_backward),
      .ifmap_filter_bias_transfer(ifmap_filter_bias_transfer), .words_num(words_num),
      .grant(grant), .done(done), .busy(busy), .err_timeout(err_timeout), .err_protocol(err_protocol)
   );

   transfer_scheduler #(.ADDR_WIDTH(20), .TIMEOUT_W(4)) u_to (
      .core_clk(core_clk), .core_reset_n(core_reset_n),
      .ifmap_req(ifmap_req), .filter_req(filter_req), .bias_req(bias_req), .back_req(back_req),
      .ifmap_words(ifmap_words), .filter_words(filter_words), .bias_words(bias_words), .back_words(back_words),
      .transfer(transfer),
      .ifmap_transfer_done(ifmap_transfer_done), .filter_transfer_done(filter_transfer_done),
      .bias_transfer_done(bias_transfer_done), .back_transfer_done(back_transfer_done),
      .clear_err(clear_err),
      .start_forward(t_start_forward), .start_backward(t_start_backward),
      .ifmap_filter_bias_transfer(t_ifmap_filter_bias_transfer), .words_num(t_words_num),
      .grant(t_grant), .done(t_done), .busy(t_busy), .err_timeout(t_err_timeout), .err_protocol(t_err_protocol)
   );

   task automatic tick();
      @(posedge core_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_inputs();
      {ifmap_req, filter_req, bias_req, back_req} = 4'b0;
      {ifmap_words, filter_words, bias_words, back_words} = '0;
      transfer = 1'b0;
      {ifmap_transfer_done, filter_transfer_done, bias_transfer_done, back_transfer_done} = 4'b0;
      clear_err = 1'b0;
   endtask

   task automatic do_reset();
      core_reset_n = 1'b0;
      clear_inputs();
      tick();
      core_reset_n = 1'b1;
      tick();
   endtask

   task automatic set_req(input logic [3:0] g, input logic v);
      if (g[0]) ifmap_req  = v;
      if (g[1]) filter_req = v;
      if (g[2]) bias_req   = v;
      if (g[3]) back_req   = v;
   endtask

   task automatic set_done(input logic [3:0] g, input logic v);
      if (g[0]) ifmap_transfer_done  = v;
      if (g[1]) filter_transfer_done = v;
      if (g[2]) bias_transfer_done   = v;
      if (g[3]) back_transfer_done   = v;
   endtask

   // Waits (bounded) for a grant, plays the controller for lat cycles, then completes the transaction.
   task automatic serve(input string tag, input logic [3:0] g, input logic [19:0] w,
                        input logic [1:0] ty, input int lat, input bit again);
      int n, nf, nb;
      bit stable;
      n = 0;
      while (grant == 4'b0 && n < 30) begin
         tick();
         n++;
      end
      chk({tag, " grant"}, grant, g);
      chk({tag, " words"}, words_num, w);
      chk({tag, " type"}, ifmap_filter_bias_transfer, ty);
      nf = 0;
      nb = 0;
      stable = 1'b1;
      for (int i = 0; i < lat; i++) begin
         nf += int'(start_forward);
         nb += int'(start_backward);
         if (grant != g || done != 4'b0) stable = 1'b0;
         tick();
      end
      chk({tag, " starts"}, {nf, nb}, g[3] ? {32'd0, 32'd1} : {32'd1, 32'd0});
      chk({tag, " stable"}, 64'(stable), 64'd1);
      set_done(g, 1'b1);
      tick();
      set_done(g, 1'b0);
      chk({tag, " done"}, done, g);
      chk({tag, " words hold"}, words_num, w);
      set_req(g, 1'b0);
      tick();
      chk({tag, " idle"}, {busy, done}, 5'b0);
      if (again) set_req(g, 1'b1);
   endtask

   initial begin
      clear_inputs();
      core_reset_n = 1'b1;
      #2;
      core_reset_n = 1'b0;
      #1;
      chk("reset outs", main_outs, 64'd0);
      chk("reset t_outs", t_outs, 64'd0);
      tick();
      core_reset_n = 1'b1;
      tick();

      // Single ifmap transfer, 110-cycle controller
      ifmap_req   = 1'b1;
      ifmap_words = 20'd100;
      #1;
      chk("t1 no comb grant", grant, 4'b0);
      tick();
      chk("t1 grant+start", {grant, start_forward, ifmap_filter_bias_transfer, words_num},
          {4'b0001, 1'b1, 2'b00, 20'd100});
      ifmap_words = 20'd5;
      serve("t1", 4'b0001, 20'd100, 2'b00, 110, 1'b0);

      // Round robin among three held forward requesters
      do_reset();
      {ifmap_req, filter_req, bias_req} = 3'b111;
      ifmap_words  = 20'd10;
      filter_words = 20'd20;
      bias_words   = 20'd30;
      serve("rr1 ifmap",  4'b0001, 20'd10, 2'b00, 3, 1'b1);
      serve("rr1 filter", 4'b0010, 20'd20, 2'b01, 4, 1'b1);
      serve("rr1 bias",   4'b0100, 20'd30, 2'b10, 3, 1'b1);
      serve("rr2 ifmap",  4'b0001, 20'd10, 2'b00, 5, 1'b0);
      serve("rr2 filter", 4'b0010, 20'd20, 2'b01, 3, 1'b0);
      serve("rr2 bias",   4'b0100, 20'd30, 2'b10, 4, 1'b0);

      // back_req arrives while filter is in flight
      filter_req   = 1'b1;
      filter_words = 20'd40;
      tick();
      chk("bk filter grant", grant, 4'b0010);
      back_req    = 1'b1;
      back_words  = 20'd50;
      ifmap_req   = 1'b1;
      ifmap_words = 20'd11;
      bias_req    = 1'b1;
      bias_words  = 20'd33;
      serve("bk filter", 4'b0010, 20'd40, 2'b01, 5, 1'b0);
      serve("bk back",   4'b1000, 20'd50, 2'b01, 4, 1'b0);
      serve("bk bias",   4'b0100, 20'd33, 2'b10, 3, 1'b0);
      serve("bk ifmap",  4'b0001, 20'd11, 2'b00, 3, 1'b0);

      // Controller busy for 20 cycles at grant
      filter_req   = 1'b1;
      filter_words = 20'd8;
      transfer     = 1'b1;
      tick();
      chk("busy grant", {grant, busy}, {4'b0010, 1'b1});
      cnt = int'(start_forward) + int'(start_backward);
      for (int i = 0; i < 19; i++) begin
         tick();
         cnt += int'(start_forward) + int'(start_backward);
      end
      chk("busy no start", cnt, 0);
      transfer = 1'b0;
      #1;
      chk("busy start released", start_forward, 1'b1);
      serve("busy", 4'b0010, 20'd8, 2'b01, 4, 1'b0);

      // Zero-count bias request completes without a start pulse
      bias_req   = 1'b1;
      bias_words = 20'd0;
      #1;
      chk("zero pre", done, 4'b0);
      tick();
      chk("zero complete", {grant, done, start_forward, start_backward}, {4'b0100, 4'b0100, 2'b00});
      bias_req = 1'b0;
      tick();
      chk("zero idle", {busy, done}, 5'b0);

      // Watchdog expiry on the TIMEOUT_W=4 instance
      do_reset();
      ifmap_req   = 1'b1;
      ifmap_words = 20'd9;
      tick();
      chk("to grant", {t_grant, t_start_forward}, {4'b0001, 1'b1});
      acc = 4'b0;
      for (int i = 0; i < 15; i++) begin
         tick();
         acc |= t_done;
      end
      chk("to before expiry", {t_err_timeout, t_grant}, {1'b0, 4'b0001});
      tick();
      acc |= t_done;
      chk("to expired", {t_err_timeout, t_grant, t_busy}, {1'b1, 4'b0000, 1'b0});
      chk("to no done", acc, 4'b0);
      ifmap_req = 1'b0;
      clear_err = 1'b1;
      tick();
      clear_err = 1'b0;
      chk("to cleared", t_err_timeout, 1'b0);
      ifmap_req    = 1'b1;
      filter_req   = 1'b1;
      filter_words = 20'd9;
      tick();
      chk("to rr unchanged", t_grant, 4'b0001);
      for (int i = 0; i < 15; i++) tick();
      ifmap_transfer_done = 1'b1;
      tick();
      ifmap_transfer_done = 1'b0;
      ifmap_req = 1'b0;
      chk("to done beats expiry", {t_done, t_err_timeout}, {4'b0001, 1'b0});

      // Wrong done input while filter is waiting
      do_reset();
      filter_req   = 1'b1;
      filter_words = 20'd6;
      tick();
      tick();
      ifmap_transfer_done = 1'b1;
      tick();
      ifmap_transfer_done = 1'b0;
      chk("proto set", {err_protocol, grant, done, busy}, {1'b1, 4'b0010, 4'b0000, 1'b1});
      repeat (3) tick();
      chk("proto still waiting", {grant, busy}, {4'b0010, 1'b1});
      filter_transfer_done = 1'b1;
      tick();
      filter_transfer_done = 1'b0;
      filter_req = 1'b0;
      chk("proto done", {done, err_protocol}, {4'b0010, 1'b1});
      tick();
      filter_req = 1'b1;
      tick();
      chk("proto regrant", grant, 4'b0010);
      tick();
      clear_err          = 1'b1;
      bias_transfer_done = 1'b1;
      tick();
      clear_err          = 1'b0;
      bias_transfer_done = 1'b0;
      chk("error beats clear", err_protocol, 1'b1);
      clear_err = 1'b1;
      tick();
      clear_err = 1'b0;
      chk("clear_err", err_protocol, 1'b0);

      // Reset in WAIT_DONE clears outputs at once and nothing is re-issued
      core_reset_n = 1'b0;
      filter_req   = 1'b0;
      #1;
      chk("mid reset outs", main_outs, 64'd0);
      tick();
      core_reset_n = 1'b1;
      acc = 4'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         acc |= grant | {2'b00, start_forward, start_backward};
      end
      chk("no reissue", acc, 4'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
